// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Brief    : MEM pipeline stage. Converts EX/MEM load/store control into a
//            req/ack data-memory transaction with stall, timeout and
//            misalignment detection.
// Revision : 1.0  initial release
// ============================================================================
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memReadInput,
    input  logic        memWriteInput,
    input  logic        memToRegInput,
    input  logic        regWriteInput,
    input  logic [31:0] aluResultInput,
    input  logic [31:0] writeDataInput,
    input  logic [4:0]  regWriteAddressInput,
    input  logic        stallInput,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    input  logic        memAck,
    input  logic [31:0] memRdata,
    output logic        stallOutput,
    output logic        memToRegOutput,
    output logic        regWriteOutput,
    output logic [31:0] dataMemoryOutput,
    output logic [31:0] aluResultOutput,
    output logic [4:0]  regWriteAddressOutput,
    output logic        misalignedOutput,
    output logic        busErrorOutput
);

    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_req;
    logic                r_we;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_err;

    logic                w_access;
    logic                w_aligned;
    logic                w_start;
    logic                w_ack;
    logic                w_timeout;

    assign w_access  = memReadInput | memWriteInput;
    assign w_aligned = (aluResultInput[1:0] == 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_ack     = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access && w_aligned) begin
                    w_start = 1'b1;
                    w_next  = S_BUSY;
                end
            end
            S_BUSY: begin
                // An ack on the final counted cycle takes priority over the timeout.
                if (memAck) begin
                    w_ack  = 1'b1;
                    w_next = S_DONE;
                end else if (r_cnt == c_cnt_max) begin
                    w_timeout = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_DONE: begin
                if (!stallInput) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else if (w_start) begin
            r_req   <= 1'b1;
            r_we    <= memWriteInput;
            r_addr  <= aluResultInput;
            r_wdata <= writeDataInput;
            r_cnt   <= '0;
        end else if (w_ack) begin
            if (!r_we) begin
                r_rdata <= memRdata;
            end
            r_req <= 1'b0;
            r_we  <= 1'b0;
            r_err <= 1'b0;
        end else if (w_timeout) begin
            // A timed-out load returns zero so stale data never reaches writeback.
            if (!r_we) begin
                r_rdata <= 32'd0;
            end
            r_req <= 1'b0;
            r_err <= 1'b1;
        end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    assign memReq   = r_req;
    assign memWe    = r_we;
    assign memAddr  = r_addr;
    assign memWdata = r_wdata;

    assign stallOutput = ~reset & (((r_state == S_IDLE) & w_access & w_aligned) |
                                   (r_state == S_BUSY));
    assign misalignedOutput      = w_access & ~w_aligned;
    assign busErrorOutput        = ~reset & (r_state == S_DONE) & r_err;
    assign regWriteOutput        = regWriteInput & ~misalignedOutput &
                                   ~((r_state == S_DONE) & r_err);
    assign memToRegOutput        = memToRegInput;
    assign aluResultOutput       = aluResultInput;
    assign regWriteAddressOutput = regWriteAddressInput;
    assign dataMemoryOutput      = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Brief    : Self-checking bench for mem_access_stage using a transaction-level
//            model of each instruction's cycle-by-cycle expected outputs.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_stage;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        memReadInput, memWriteInput, memToRegInput, regWriteInput;
    logic [31:0] aluResultInput, writeDataInput;
    logic [4:0]  regWriteAddressInput;
    logic        stallInput;
    logic        memReq, memWe;
    logic [31:0] memAddr, memWdata;
    logic        memAck;
    logic [31:0] memRdata;
    logic        stallOutput, memToRegOutput, regWriteOutput;
    logic [31:0] dataMemoryOutput, aluResultOutput;
    logic [4:0]  regWriteAddressOutput;
    logic        misalignedOutput, busErrorOutput;

    mem_access_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .memReadInput(memReadInput), .memWriteInput(memWriteInput),
        .memToRegInput(memToRegInput), .regWriteInput(regWriteInput),
        .aluResultInput(aluResultInput), .writeDataInput(writeDataInput),
        .regWriteAddressInput(regWriteAddressInput), .stallInput(stallInput),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memAck(memAck), .memRdata(memRdata),
        .stallOutput(stallOutput), .memToRegOutput(memToRegOutput),
        .regWriteOutput(regWriteOutput), .dataMemoryOutput(dataMemoryOutput),
        .aluResultOutput(aluResultOutput),
        .regWriteAddressOutput(regWriteAddressOutput),
        .misalignedOutput(misalignedOutput), .busErrorOutput(busErrorOutput)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int stall_cnt = 0;
    int berr_cnt = 0;
    bit chk_en = 1'b0;

    // Expected outputs for the current cycle, set by the stimulus model.
    logic        e_stall, e_req, e_we, e_bus, e_berr, e_rw, e_mis;
    logic [31:0] e_addr, e_wdata, e_dmem;
    logic [31:0] model_rdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (stallOutput) stall_cnt++;
            if (busErrorOutput) berr_cnt++;
            chk("stallOutput", stallOutput, e_stall);
            chk("memReq", memReq, e_req);
            if (e_bus) begin
                chk("memWe", memWe, e_we);
                chk("memAddr", memAddr, e_addr);
                chk("memWdata", memWdata, e_wdata);
            end
            chk("dataMemoryOutput", dataMemoryOutput, e_dmem);
            chk("busErrorOutput", busErrorOutput, e_berr);
            chk("regWriteOutput", regWriteOutput, e_rw);
            chk("misalignedOutput", misalignedOutput, e_mis);
            chk("memToRegOutput", memToRegOutput, memToRegInput);
            chk("aluResultOutput", aluResultOutput, aluResultInput);
            chk("regWriteAddressOutput", regWriteAddressOutput, regWriteAddressInput);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One instruction in EX/MEM. ackn: BUSY cycle (1-based) that gets the ack;
    // 0 or >T means the bus never answers. dstalls: stallInput cycles in DONE.
    task automatic instr(input bit rd, input bit wr, input bit rw,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int ackn, input logic [31:0] rdv, input int dstalls);
        bit acc, al, to;
        int len;
        acc = rd | wr;
        al  = (addr[1:0] == 2'b00);
        memReadInput         = rd;
        memWriteInput        = wr;
        memToRegInput        = rd;
        regWriteInput        = rw;
        aluResultInput       = addr;
        writeDataInput       = wd;
        regWriteAddressInput = 5'($urandom);
        e_mis  = acc & ~al;
        e_bus  = 1'b0;
        e_req  = 1'b0;
        e_berr = 1'b0;
        e_dmem = model_rdata;
        memAck     = 1'($urandom);
        memRdata   = $urandom;
        stallInput = 1'($urandom);
        if (!(acc && al)) begin
            e_stall = 1'b0;
            e_rw    = rw & ~e_mis;
            cyc();
            return;
        end
        to  = (ackn < 1) || (ackn > T);
        len = to ? T : ackn;
        e_stall = 1'b1;
        e_rw    = rw;
        cyc();
        for (int k = 1; k <= len; k++) begin
            memAck     = (k == ackn);
            memRdata   = (k == ackn) ? rdv : $urandom;
            stallInput = 1'($urandom);
            e_req   = 1'b1;
            e_bus   = 1'b1;
            e_we    = wr;
            e_addr  = addr;
            e_wdata = wd;
            cyc();
        end
        if (!wr) model_rdata = to ? 32'd0 : rdv;
        for (int j = 0; j <= dstalls; j++) begin
            memAck     = 1'($urandom);
            memRdata   = $urandom;
            stallInput = (j < dstalls);
            e_stall = 1'b0;
            e_req   = 1'b0;
            e_bus   = 1'b0;
            e_berr  = to;
            e_rw    = rw & ~to;
            e_dmem  = model_rdata;
            cyc();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, b0;
        bit rd, wr;
        logic [31:0] a;
        reset = 1'b1;
        memReadInput = 1'b0; memWriteInput = 1'b0; memToRegInput = 1'b0;
        regWriteInput = 1'b0; aluResultInput = 32'h100; writeDataInput = 32'd0;
        regWriteAddressInput = 5'd0; stallInput = 1'b0; memAck = 1'b0; memRdata = 32'd0;
        memReadInput = 1'b1;
        model_rdata = 32'd0;
        repeat (2) cyc();
        chk("reset memReq", memReq, 1'b0);
        chk("reset memAddr", memAddr, 32'd0);
        chk("reset memWdata", memWdata, 32'd0);
        chk("reset dataMemoryOutput", dataMemoryOutput, 32'd0);
        chk("reset stallOutput", stallOutput, 1'b0);
        chk("reset busErrorOutput", busErrorOutput, 1'b0);
        chk("reset aluResult passthru", aluResultOutput, 32'h100);
        memReadInput = 1'b0;
        reset = 1'b0;
        cyc();
        chk_en = 1'b1;

        instr(0, 0, 1, 32'h10, 32'd0, 0, 32'd0, 0);
        s0 = stall_cnt;
        instr(1, 0, 1, 32'h100, 32'd0, 3, 32'hDEADBEEF, 0);
        chk("load stall cycles", stall_cnt - s0, 4);
        chk("load data", dataMemoryOutput, 32'hDEADBEEF);
        s0 = stall_cnt;
        instr(0, 1, 0, 32'h200, 32'h12345678, 1, 32'h0BADF00D, 0);
        chk("store stall cycles", stall_cnt - s0, 2);
        chk("store wdata held", memWdata, 32'h12345678);
        chk("store keeps rdata", dataMemoryOutput, 32'hDEADBEEF);
        s0 = stall_cnt;
        instr(1, 0, 1, 32'h102, 32'd0, 1, 32'h11111111, 0);
        chk("misaligned stall cycles", stall_cnt - s0, 0);
        s0 = stall_cnt; b0 = berr_cnt;
        instr(1, 0, 1, 32'h300, 32'd0, 0, 32'd0, 2);
        chk("timeout stall cycles", stall_cnt - s0, T + 1);
        chk("timeout busError cycles", berr_cnt - b0, 3);
        chk("timeout data", dataMemoryOutput, 32'd0);
        s0 = stall_cnt; b0 = berr_cnt;
        instr(1, 0, 1, 32'h304, 32'd0, T, 32'hCAFEF00D, 3);
        chk("late ack stall cycles", stall_cnt - s0, T + 1);
        chk("late ack no busError", berr_cnt - b0, 0);
        chk("late ack data", dataMemoryOutput, 32'hCAFEF00D);

        // Reset during the second BUSY cycle.
        chk_en = 1'b0;
        memReadInput = 1'b1; memWriteInput = 1'b0; aluResultInput = 32'h400;
        memAck = 1'b0; stallInput = 1'b0;
        cyc();
        cyc();
        chk("busy memReq", memReq, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("async reset memReq", memReq, 1'b0);
        chk("async reset stallOutput", stallOutput, 1'b0);
        memReadInput = 1'b0;
        memAck = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        chk("late ack ignored memReq", memReq, 1'b0);
        chk("late ack ignored stall", stallOutput, 1'b0);
        chk("reset cleared rdata", dataMemoryOutput, 32'd0);
        model_rdata = 32'd0;
        memAck = 1'b0;
        cyc();
        chk_en = 1'b1;

        for (int i = 0; i < 80; i++) begin
            int kind;
            kind = $urandom_range(0, 2);
            rd = (kind == 1);
            wr = (kind == 2);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            instr(rd, wr, 1'($urandom), a, $urandom, $urandom_range(0, T + 1),
                  $urandom, $urandom_range(0, 3));
        end
        chk_en = 1'b0;
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access (MEM) stage logic between the EX/MEM pipeline register and the MEM/WB pipeline register. It turns load/store control from EX/MEM into a request/acknowledge transaction on a multi-cycle data-memory bus. While the transaction is outstanding it stalls the pipeline through the hazard unit. It then presents read data and pass-through control to MEM/WB, and detects misaligned addresses and bus timeouts.

## Interface
- TIMEOUT_CYCLES, 16: BUSY cycles without `memAck` before the access is aborted; legal range ≥2.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- memReadInput  input  1  load in EX/MEM.
- memWriteInput  input  1  store in EX/MEM.
- memToRegInput  input  1  writeback select, passed through.
- regWriteInput  input  1  register write enable.
- aluResultInput  input  32  effective address / ALU result.
- writeDataInput  input  32  store data.
- regWriteAddressInput  input  5  destination register.
- stallInput  input  1  downstream/global stall; MEM/WB not loading this cycle.
- memReq  output  1  bus request, registered.
- memWe  output  1  bus write enable, registered.
- memAddr  output  32  bus address, registered.
- memWdata  output  32  bus write data, registered.
- memAck  input  1  bus completion, sampled only in BUSY.
- memRdata  input  32  read data, valid with `memAck`.
- stallOutput  output  1  to hazard unit; holds PC, IF/ID, ID/EX, EX/MEM.
- memToRegOutput  output  1  to MEM/WB.
- regWriteOutput  output  1  to MEM/WB, gated.
- dataMemoryOutput  output  32  captured read data register.
- aluResultOutput  output  32  pass-through.
- regWriteAddressOutput  output  5  pass-through.
- misalignedOutput  output  1  exception flag, combinational.
- busErrorOutput  output  1  timeout flag, valid in DONE.

## Operation
- Define `access = memReadInput | memWriteInput` and `aligned = aluResultInput[1:0] == 0`.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If `access & aligned`: register `memReq=1`, `memWe=memWriteInput`, `memAddr=aluResultInput`, `memWdata=writeDataInput`; clear the timeout counter; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Bus outputs hold their values.
  - On `memAck`: for a read, load `memRdata` into the read-data register; for a write, leave the register unchanged. Clear `memReq`/`memWe`, go to DONE with the error bit 0.
  - With no ack and counter == TIMEOUT_CYCLES-1: clear `memReq`, load 0 into the read-data register if the access is a read, set the error bit, go to DONE.
  - Otherwise increment the counter.
- DONE:
  - If `stallInput=0`, go to IDLE.
  - Otherwise stay in DONE. The read-data register and error bit are held.
- `stallOutput = (IDLE & access & aligned) | BUSY`. It is 0 in DONE and for non-memory or misaligned instructions.
- `misalignedOutput = access & ~aligned`, in any state. No bus request is made and no stall is raised.
- `regWriteOutput = regWriteInput & ~misalignedOutput & ~(DONE & errorBit)`.
- `memToRegOutput`, `aluResultOutput` and `regWriteAddressOutput` pass straight through combinationally.
- `dataMemoryOutput` always equals the read-data register.
- `busErrorOutput = DONE & errorBit`.
- `memAck` is ignored outside BUSY.

## Timing
- Reset (asynchronous, immediate): state IDLE; `memReq`, `memWe` = 0; `memAddr`, `memWdata`, read-data register, counter and error bit = 0.
  - Outputs during reset: `stallOutput` and `busErrorOutput` are 0; pass-through outputs follow their inputs.
- Reset mid-BUSY drops `memReq` without waiting for `memAck`; a late ack is then ignored.
- Non-memory instruction: zero added latency.
- Memory access where ack arrives on the n-th BUSY cycle (n≥1): `stallOutput` is high for n+1 cycles (the IDLE cycle plus n BUSY cycles). The DONE cycle follows, with MEM/WB loading at the end of DONE.
- Minimum access: 2 stall cycles (IDLE, then BUSY with ack in the same cycle).
- Timeout: exactly TIMEOUT_CYCLES BUSY cycles, then DONE.
- Ack arriving on the same cycle the counter hits TIMEOUT_CYCLES-1: the ack wins and the access completes normally.
- `stallInput` held high during DONE: stay in DONE, no new request, outputs stable.

## Test plan
- ALU op, `regWriteInput=1`, `aluResultInput=0x10`, no access → `stallOutput=0`, `memReq=0`, outputs pass-through in the same cycle.
- Load at 0x100, `memAck` on 3rd BUSY cycle with `memRdata=0xDEADBEEF` → `stallOutput` high for 4 cycles; `memAddr=0x100`; DONE shows `dataMemoryOutput=0xDEADBEEF`, `regWriteOutput=1`.
- Store at 0x200, data 0x12345678, immediate ack → `memWe=1`, `memWdata=0x12345678`, 2 stall cycles; `dataMemoryOutput` keeps its previous value.
- Load at 0x102 → `misalignedOutput=1`, `regWriteOutput=0`, `memReq` never asserted, `stallOutput=0`.
- TIMEOUT_CYCLES=4, load with no ack → 4 BUSY cycles, then DONE with `busErrorOutput=1`, `regWriteOutput=0`, `dataMemoryOutput=0`; ack on 4th BUSY cycle instead → normal completion.
- Assert reset in 2nd BUSY cycle → `memReq=0` immediately, state IDLE.
- `stallInput=1` for 3 cycles in DONE → state held in DONE for those cycles with no new `memReq`.
